// File: rtl/mem_responder.sv
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Responder end of the core's data-memory port. Accepts one
//             read/write request at a time over valid/ready, waits LATENCY
//             cycles, performs a word access on internal storage and returns
//             the response over valid/ready.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous reset, active-low
//             req_valid  - request present
//             req_ready  - responder can accept (registered)
//             req_wen    - 1 = write, 0 = read
//             req_addr   - byte address, [1:0] ignored
//             req_wdata  - write data
//             req_wmask  - byte-lane write enables
//             rsp_valid  - response present
//             rsp_ready  - requester takes response
//             rsp_rdata  - read data (0 for writes and errors)
//             rsp_err    - address decode error
//  Config   : MEM_RESPONDER_ERR_EN - when defined, addresses outside the
//             storage window return rsp_err=1 and never write; otherwise the
//             word index wraps modulo DEPTH_WORDS and rsp_err is always 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
   parameter int                LATENCY     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wmask,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int c_LANES = DATA_W / 8;
   localparam int c_IDX_W = $clog2(DEPTH_WORDS);
   localparam int c_CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_req_ready;
   logic                  r_wen;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [c_LANES-1:0]    r_wmask;
   logic                  r_rsp_valid;
   logic [DATA_W-1:0]     r_rsp_rdata;
   logic                  r_rsp_err;
   logic [DATA_W-1:0]     r_mem [0:DEPTH_WORDS-1];

   logic                  w_accept;
   logic [ADDR_W-1:0]     w_offset;
   logic [c_IDX_W-1:0]    w_idx;
   logic                  w_err;
   logic                  w_mem_we;

   assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid;

   // Offset from the window base; bits above the index simply wrap away when
   // no range check is built in.
   assign w_offset = r_addr - BASE_ADDR;
   assign w_idx    = w_offset[c_IDX_W+1:2];

`ifdef MEM_RESPONDER_ERR_EN
   localparam logic [ADDR_W:0] c_SPAN = (ADDR_W+1)'(4 * DEPTH_WORDS);
   // Addresses below the base wrap to a huge offset, so one unsigned compare
   // covers both ends of the window.
   assign w_err = ({1'b0, w_offset} >= c_SPAN);
`else
   assign w_err = 1'b0;
`endif

   // Byte-lane bits and the wrapped-away upper offset bits carry no meaning.
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, w_offset[1:0], w_offset[ADDR_W-1:c_IDX_W+2]};

   // The write fires on the ACCESS edge only; an asynchronous reset before
   // that edge forces the state out of ACCESS, so the write is dropped.
   assign w_mem_we = (r_state == S_ACCESS) && r_wen && !w_err;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (LATENCY == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            // cnt==0 cannot occur here, but escaping keeps the FSM live.
            if (r_cnt <= c_CNT_W'(1)) begin
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request capture, wait counter and response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_wen       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_wen       <= req_wen;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_wmask     <= req_wmask;
                  r_cnt       <= c_CNT_W'(LATENCY);
                  r_req_ready <= 1'b0;
               end else begin
                  // Raises ready on the first edge after reset release.
                  r_req_ready <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            S_ACCESS: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= w_err;
               r_rsp_rdata <= (r_wen || w_err) ? '0 : r_mem[w_idx];
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage: not reset, byte-lane masked writes
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < c_LANES; i++) begin
            if (r_wmask[i]) begin
               r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Directed self-checking bench for mem_responder (LATENCY=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

   localparam int c_LAT = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_responder #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h8000_0000),
      .LATENCY     (c_LAT)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
      int n;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = mask;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
      step();
      req_valid = 1'b0;
      // Scribble the bus to show changes after accept are ignored.
      req_wdata = 32'hA5A5_A5A5;
      req_addr  = 32'h8000_0FF0;
      check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
   endtask

   task automatic wait_rsp(input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!rsp_valid && lat < 20);
      check("rsp_latency", lat, c_LAT + 1);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
   endtask

   task automatic finish_rsp();
      step();
      check("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
      check("rdata_clear", rsp_rdata, 32'd0);
      check("ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic xfer(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] exp_rdata, input logic exp_err);
      send_req(wen, addr, wdata, mask);
      wait_rsp(exp_rdata, exp_err);
      finish_rsp();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      rsp_ready = 1'b1;

      // ---- Reset values -------------------------------------------------
      #2 rst = 1'b0;
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      step();
      step();
      rst = 1'b1;
      check("ready_before_edge", {31'd0, req_ready}, 32'd0);
      step();
      check("ready_after_release", {31'd0, req_ready}, 32'd1);

      // ---- Full write then read ----------------------------------------
      xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // ---- Partial write -----------------------------------------------
      xfer(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      xfer(1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0);
      xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1122_AA44, 1'b0);

      // ---- Zero-mask write leaves storage alone ------------------------
      xfer(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
      xfer(1'b0, 32'h8000_0023, 32'h0, 4'h0, 32'h1122_AA44, 1'b0);

      // ---- Backpressure ------------------------------------------------
      rsp_ready = 1'b0;
      send_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
      wait_rsp(32'h1122_AA44, 1'b0);
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0020;
      req_wdata = 32'hFFFF_FFFF;
      req_wmask = 4'hF;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rdata", rsp_rdata, 32'h1122_AA44);
         check("bp_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      finish_rsp();
      xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1122_AA44, 1'b0);

      // ---- Out-of-window address ---------------------------------------
      xfer(1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
`ifdef MEM_RESPONDER_ERR_EN
      xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);
      xfer(1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
      xfer(1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
      xfer(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
      xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b0);
`else
      xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
      xfer(1'b1, 32'h7FFF_FFFC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0);
      xfer(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0);
`endif

      // ---- Reset while a response is held ------------------------------
      rsp_ready = 1'b0;
      send_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      wait_rsp(32'hDEAD_BEEF, 1'b0);
      rst = 1'b0;
      #1;
      check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_rdata", rsp_rdata, 32'd0);
      check("midrst_ready", {31'd0, req_ready}, 32'd0);
      step();
      rst = 1'b1;
      rsp_ready = 1'b1;
      step();
      check("midrst_ready_back", {31'd0, req_ready}, 32'd1);

      // ---- Reset during WAIT drops the write ---------------------------
      xfer(1'b1, 32'h8000_0000, 32'h0000_0077, 4'hF, 32'h0, 1'b0);
      send_req(1'b1, 32'h8000_0000, 32'h0000_0055, 4'hF);
      step();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("dropped_no_rsp", {31'd0, rsp_valid}, 32'd0);
         step();
      end
      xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0077, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
